// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operand width, FSM state
// encoding and a two's-complement negate helper.
package mult_div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_t;

  function automatic logic [DATA_W-1:0] negate_w(input logic [DATA_W-1:0] x);
    return ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control FSM (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic              start_mult;
  logic              start_div;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start_mult, start_div, a, b,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output busy, done, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring, on
// magnitudes with sign fix-up); both share the counter and working register.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mult_div_unit_if.slave md
);

  md_state_t         state;
  logic [DATA_W:0]   acc;     // Booth accumulator / partial remainder
  logic [DATA_W:0]   m;       // sign-extended multiplicand / divisor magnitude
  logic [DATA_W-1:0] q;       // multiplier / dividend magnitude, becomes result
  logic              q_m1;
  logic [CNT_W-1:0]  count;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W:0]   booth_sum;
  logic [DATA_W:0]   booth_acc;
  logic [DATA_W-1:0] booth_q;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic [DATA_W:0]   div_acc;
  logic [DATA_W-1:0] div_q;

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
    booth_q   = {booth_sum[0], q[DATA_W-1:1]};

    // Remainder stays below the divisor (<= 2^31), so bit DATA_W of the
    // difference is a reliable borrow flag.
    div_shift = {acc[DATA_W-1:0], q[DATA_W-1]};
    div_diff  = div_shift - m;
    if (div_diff[DATA_W]) begin
      div_acc = div_shift;
      div_q   = {q[DATA_W-2:0], 1'b0};
    end else begin
      div_acc = div_diff;
      div_q   = {q[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      m           <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      md.busy     <= 1'b0;
      md.done     <= 1'b0;
      md.div_zero <= 1'b0;
      md.hi_out   <= '0;
      md.lo_out   <= '0;
    end else begin
      md.done     <= 1'b0;
      md.div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start_mult) begin
            acc     <= '0;
            m       <= {md.a[DATA_W-1], md.a};
            q       <= md.b;
            q_m1    <= 1'b0;
            count   <= CNT_W'(DATA_W - 1);
            state   <= MULT;
            md.busy <= 1'b1;
          end else if (md.start_div) begin
            if (md.b != '0) begin
              acc     <= '0;
              m       <= {1'b0, md.b[DATA_W-1] ? negate_w(md.b) : md.b};
              q       <= md.a[DATA_W-1] ? negate_w(md.a) : md.a;
              neg_q   <= md.a[DATA_W-1] ^ md.b[DATA_W-1];
              neg_r   <= md.a[DATA_W-1];
              count   <= CNT_W'(DATA_W - 1);
              state   <= DIV;
              md.busy <= 1'b1;
            end else begin
              state       <= DONE;
              md.done     <= 1'b1;
              md.div_zero <= 1'b1;
            end
          end
        end
        MULT: begin
          acc  <= booth_acc;
          q    <= booth_q;
          q_m1 <= q[0];
          if (count == '0) begin
            md.hi_out <= booth_acc[DATA_W-1:0];
            md.lo_out <= booth_q;
            md.busy   <= 1'b0;
            md.done   <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DIV: begin
          acc <= div_acc;
          q   <= div_q;
          if (count == '0) begin
            md.lo_out <= neg_q ? negate_w(div_q) : div_q;
            md.hi_out <= neg_r ? negate_w(div_acc[DATA_W-1:0]) : div_acc[DATA_W-1:0];
            md.busy   <= 1'b0;
            md.done   <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, div-by-zero,
// start priority, ignored mid-operation starts and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if md();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for done, check the result cycle and
  // that done drops again on the following cycle.
  task automatic do_op(input string tag, input logic sm, input logic sd,
                       input logic [31:0] av, input logic [31:0] bv, input int inject,
                       input int exp_lat, input logic exp_busy0,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dz);
    int   edges;
    logic busy0;
    edges = 0;
    @(negedge clk);
    md.start_mult = sm;
    md.start_div  = sd;
    md.a          = av;
    md.b          = bv;
    @(negedge clk);
    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    busy0 = md.busy;
    while (!md.done && edges < 100) begin
      @(negedge clk);
      edges++;
      md.start_div = (edges == inject);
    end
    md.start_div = 1'b0;
    check({tag, " latency"},  64'(edges),      64'(exp_lat));
    check({tag, " busy0"},    64'(busy0),      64'(exp_busy0));
    check({tag, " done"},     64'(md.done),    64'd1);
    check({tag, " busy"},     64'(md.busy),    64'd0);
    check({tag, " div_zero"}, 64'(md.div_zero), 64'(exp_dz));
    check({tag, " hi"},       64'(md.hi_out),  64'(exp_hi));
    check({tag, " lo"},       64'(md.lo_out),  64'(exp_lo));
    @(negedge clk);
    check({tag, " done_drop"}, 64'(md.done),     64'd0);
    check({tag, " dz_drop"},   64'(md.div_zero), 64'd0);
  endtask

  initial begin
    int dones;
    reset         = 1'b1;
    md.start_mult = 1'b0;
    md.start_div  = 1'b0;
    md.a          = '0;
    md.b          = '0;
    repeat (2) @(negedge clk);
    check("rst busy",     64'(md.busy),     64'd0);
    check("rst done",     64'(md.done),     64'd0);
    check("rst div_zero", 64'(md.div_zero), 64'd0);
    check("rst hi",       64'(md.hi_out),   64'd0);
    check("rst lo",       64'(md.lo_out),   64'd0);
    reset = 1'b0;

    do_op("mul 7*-3",   1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, -1, 32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    do_op("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, 32, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0);
    do_op("div -7/2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         -1, 32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("div 100/0",  1'b0, 1'b1, 32'd100,       32'd0,         -1,  0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    do_op("div 20/-6",  1'b0, 1'b1, 32'd20,        32'hFFFF_FFFA, -1, 32, 1'b1, 32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("div -100/7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         -1, 32, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    do_op("both 6*4",   1'b1, 1'b1, 32'd6,         32'd4,          5, 32, 1'b1, 32'd0,         32'd24,        1'b0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done) dones++;
    end
    check("both extra_done", 64'(dones), 64'd0);

    do_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32, 1'b1, 32'd0,         32'h8000_0000, 1'b0);

    // Abort a divide at iteration 10 with reset.
    @(negedge clk);
    md.start_div = 1'b1;
    md.a         = 32'd50;
    md.b         = 32'd5;
    @(negedge clk);
    md.start_div = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort state", 64'(dut.state), 64'(IDLE));
    check("abort hi",    64'(md.hi_out), 64'd0);
    check("abort lo",    64'(md.lo_out), 64'd0);
    check("abort done",  64'(md.done),   64'd0);
    check("abort busy",  64'(md.busy),   64'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (md.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'd0);

    do_op("div 50/5",   1'b0, 1'b1, 32'd50,        32'd5,         -1, 32, 1'b1, 32'd0,         32'd10,        1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
